// File: rtl/xtest_loader_if.sv
// Handshake and read-port bundle between the test-image loader and its
// neighbours: the control path, the pixel source and the w10 datapath.
interface xtest_loader_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10
);
  logic              start_dload;
  logic              xtest_in_valid;
  logic [PIX_W-1:0]  xtest_in;
  logic              xtest_in_ready;
  logic              dload_done;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  modport master (
    output start_dload, xtest_in_valid, xtest_in, rd_addr,
    input  xtest_in_ready, dload_done, pix_cnt, rd_data
  );

  modport slave (
    input  start_dload, xtest_in_valid, xtest_in, rd_addr,
    output xtest_in_ready, dload_done, pix_cnt, rd_data
  );
endinterface

// File: rtl/xtest_loader.sv
// Loads one NPIX-pixel test image over valid/ready into a register file,
// flags completion, and serves pixels through a combinational read port.
module xtest_loader #(
  parameter int NPIX   = 784,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  xtest_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [PIX_W-1:0]  r_mem [NPIX];
  logic              w_accept;
  logic              w_last;
  logic              w_in_range;

  // Abort takes priority: a dropped start_dload blocks the accept outright.
  assign w_accept   = (r_state == LOAD) && bus.start_dload && bus.xtest_in_valid;
  assign w_last     = (r_pix_cnt == ADDR_W'(NPIX - 1));
  assign w_in_range = (bus.rd_addr < ADDR_W'(NPIX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start_dload) w_next = LOAD;
      LOAD: begin
        if (!bus.start_dload)       w_next = IDLE;
        else if (w_accept && w_last) w_next = DONE;
      end
      DONE:    if (!bus.start_dload) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_pix_cnt <= '0;
    else if (r_state == IDLE && bus.start_dload) r_pix_cnt <= '0;
    else if (w_accept)                           r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
  end

  // Storage is deliberately left out of reset; a completed load defines it.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_pix_cnt] <= bus.xtest_in;
  end

  assign bus.xtest_in_ready = (r_state == LOAD);
  assign bus.dload_done     = (r_state == DONE);
  assign bus.pix_cnt        = r_pix_cnt;
  assign bus.rd_data        = w_in_range ? r_mem[bus.rd_addr] : '0;

endmodule

// File: tb/tb_xtest_loader.sv
// Directed bench for xtest_loader: read-back tables after each frame plus
// hand-written sequences for abort, async reset and last-pixel abort.
module tb_xtest_loader;
  localparam int NPIX = 784;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xtest_loader_if #(.PIX_W(8), .ADDR_W(10)) bus();
  xtest_loader #(.NPIX(NPIX), .PIX_W(8), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          phase;
    logic [9:0]  addr;
    logic [7:0]  exp;
    string       name;
  } rv_t;

  rv_t        tbl [11];
  logic [7:0] model [NPIX];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixval(input int kind, input int i);
    int v;
    v = (kind == 0) ? i : (783 - i);
    return v[7:0];
  endfunction

  task automatic apply_tbl(input int phase, input string tag);
    for (int k = 0; k < 11; k++) begin
      if (tbl[k].phase == phase) begin
        bus.rd_addr = tbl[k].addr;
        #1;
        chk({tag, "_", tbl[k].name}, int'(bus.rd_data), int'(tbl[k].exp));
      end
    end
  endtask

  task automatic readback_all(input string tag);
    int bad = 0;
    for (int a = 0; a < NPIX; a++) begin
      bus.rd_addr = 10'(a);
      #1;
      if (bus.rd_data !== model[a]) bad++;
    end
    chk({tag, "_readback_bad"}, bad, 0);
  endtask

  // Raises start_dload and streams n_acc pixels; leaves start_dload high.
  task automatic do_load(input int kind, input bit gapped, input int n_acc, input string tag);
    int i = 0;
    int cyc = 0;
    bit bad = 1'b0;
    bus.start_dload    = 1'b1;
    bus.xtest_in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_on"}, int'(bus.xtest_in_ready), 1);
    chk({tag, "_cnt_clear"}, int'(bus.pix_cnt), 0);
    while (i < n_acc && cyc < 10000) begin
      bus.xtest_in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.xtest_in       = bus.xtest_in_valid ? pixval(kind, i) : 8'hEE;
      @(posedge clk);
      if (bus.xtest_in_valid) begin
        model[i] = bus.xtest_in;
        i++;
      end
      #1;
      cyc++;
      if (bus.pix_cnt != 10'(i)) bad = 1'b1;
      if (bus.dload_done && i < NPIX) bad = 1'b1;
      if (!bus.xtest_in_ready && i < NPIX) bad = 1'b1;
    end
    bus.xtest_in_valid = 1'b0;
    bus.xtest_in       = 8'h00;
    chk({tag, "_accepts"}, i, n_acc);
    chk({tag, "_track_bad"}, int'(bad), 0);
  endtask

  initial begin
    tbl[0]  = '{0, 10'd0,    8'h00, "a0"};
    tbl[1]  = '{0, 10'd1,    8'h01, "a1"};
    tbl[2]  = '{0, 10'd255,  8'hFF, "a255"};
    tbl[3]  = '{0, 10'd256,  8'h00, "a256"};
    tbl[4]  = '{0, 10'd783,  8'h0F, "a783"};
    tbl[5]  = '{0, 10'd800,  8'h00, "a800"};
    tbl[6]  = '{0, 10'd1023, 8'h00, "a1023"};
    tbl[7]  = '{1, 10'd0,    8'h0F, "b0"};
    tbl[8]  = '{1, 10'd528,  8'hFF, "b528"};
    tbl[9]  = '{1, 10'd783,  8'h00, "b783"};
    tbl[10] = '{1, 10'd800,  8'h00, "b800"};

    bus.start_dload    = 1'b0;
    bus.xtest_in_valid = 1'b0;
    bus.xtest_in       = 8'h00;
    bus.rd_addr        = 10'd0;

    #1;
    chk("rst_ready", int'(bus.xtest_in_ready), 0);
    chk("rst_done",  int'(bus.dload_done), 0);
    chk("rst_cnt",   int'(bus.pix_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 0: continuous stream of index mod 256
    do_load(0, 1'b0, NPIX, "cont");
    chk("cont_done", int'(bus.dload_done), 1);
    chk("cont_ready_off", int'(bus.xtest_in_ready), 0);
    chk("cont_cnt", int'(bus.pix_cnt), NPIX);
    @(posedge clk); #1;
    chk("cont_done_hold", int'(bus.dload_done), 1);
    apply_tbl(0, "cont");
    bus.start_dload = 1'b0;
    @(posedge clk); #1;
    chk("cont_done_fall", int'(bus.dload_done), 0);

    // Valid with no start_dload must be ignored
    bus.xtest_in_valid = 1'b1;
    bus.xtest_in       = 8'hAA;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ready", int'(bus.xtest_in_ready), 0);
    chk("idle_done",  int'(bus.dload_done), 0);
    bus.xtest_in_valid = 1'b0;
    apply_tbl(0, "idle");

    // Abort after 100 accepts; the abort cycle offers a pixel that must not land
    do_load(1, 1'b0, 100, "abort");
    bus.start_dload    = 1'b0;
    bus.xtest_in_valid = 1'b1;
    bus.xtest_in       = 8'h55;
    @(posedge clk); #1;
    bus.xtest_in_valid = 1'b0;
    chk("abort_ready", int'(bus.xtest_in_ready), 0);
    chk("abort_done",  int'(bus.dload_done), 0);
    chk("abort_cnt",   int'(bus.pix_cnt), 100);
    bus.rd_addr = 10'd99;  #1; chk("abort_rd99",  int'(bus.rd_data), 8'hAC);
    bus.rd_addr = 10'd100; #1; chk("abort_rd100", int'(bus.rd_data), 8'h64);

    // Frame 1: gapped valid, value 783-index, replaces frame 0 entirely
    do_load(1, 1'b1, NPIX, "gap");
    chk("gap_done", int'(bus.dload_done), 1);
    chk("gap_ready_off", int'(bus.xtest_in_ready), 0);
    readback_all("gap");
    apply_tbl(1, "gap");
    bus.start_dload = 1'b0;
    @(posedge clk); #1;

    // Async reset partway through a load, asserted between clock edges
    do_load(0, 1'b0, 400, "rmid");
    #2 rst = 1'b1;
    #1;
    chk("rmid_ready", int'(bus.xtest_in_ready), 0);
    chk("rmid_cnt",   int'(bus.pix_cnt), 0);
    chk("rmid_done",  int'(bus.dload_done), 0);
    bus.start_dload = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rmid_stay_idle", int'(bus.xtest_in_ready), 0);
    do_load(0, 1'b0, NPIX, "rfull");
    chk("rfull_done", int'(bus.dload_done), 1);
    readback_all("rfull");
    bus.start_dload = 1'b0;
    @(posedge clk); #1;

    // start_dload drops in the same cycle as the final pixel: no write
    do_load(1, 1'b0, NPIX - 1, "last");
    bus.start_dload    = 1'b0;
    bus.xtest_in_valid = 1'b1;
    bus.xtest_in       = pixval(1, NPIX - 1);
    @(posedge clk); #1;
    bus.xtest_in_valid = 1'b0;
    chk("last_done",  int'(bus.dload_done), 0);
    chk("last_ready", int'(bus.xtest_in_ready), 0);
    chk("last_cnt",   int'(bus.pix_cnt), NPIX - 1);
    bus.rd_addr = 10'd783; #1;
    chk("last_rd783", int'(bus.rd_data), 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
